// File: rtl/mem_access.sv
// mem_access: MEM-stage load/store unit of the MIPS pipeline.
// Drives the SRAM-like data bus and holds the pipeline until each access retires.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  mem_aluop,
  input  logic [31:0] mem_mem_addr,
  input  logic [31:0] mem_reg2,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic        flush,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq_o,
  output logic        adel_o,
  output logic        ades_o,
  output logic [31:0] badvaddr_o,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic [31:0] data_rdata,
  input  logic        data_data_ok
);

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;

  logic        is_load, is_store, sgn;
  logic [1:0]  size;
  logic        misalign, access_valid, issue;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_data;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sgn      = 1'b0;
    size     = 2'd0;
    case (mem_aluop)
      EXE_LB_OP:  begin is_load = 1'b1; sgn = 1'b1; end
      EXE_LBU_OP: is_load = 1'b1;
      EXE_LH_OP:  begin is_load = 1'b1; sgn = 1'b1; size = 2'd1; end
      EXE_LHU_OP: begin is_load = 1'b1; size = 2'd1; end
      EXE_LW_OP:  begin is_load = 1'b1; size = 2'd2; end
      EXE_SB_OP:  is_store = 1'b1;
      EXE_SH_OP:  begin is_store = 1'b1; size = 2'd1; end
      EXE_SW_OP:  begin is_store = 1'b1; size = 2'd2; end
      default:    ;
    endcase
  end

  assign misalign = ((size == 2'd1) & mem_mem_addr[0])
                  | ((size == 2'd2) & (mem_mem_addr[1:0] != 2'd0));
  assign access_valid = (is_load | is_store) & ~misalign & ~flush;
  assign issue = (state_q == S_IDLE) & access_valid;

  // An accepted transfer must always be drained, even if flushed.
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE:
        if (access_valid)
          state_d = data_addr_ok ? S_WAIT : S_REQ;
      S_REQ:
        if (data_addr_ok)
          state_d = flush ? S_DRAIN : S_WAIT;
        else if (flush)
          state_d = S_IDLE;
      S_WAIT:
        if (data_data_ok) begin
          state_d = S_DONE;
          rdata_d = data_rdata;
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      S_DONE:  state_d = S_IDLE;
      S_DRAIN:
        if (data_data_ok)
          state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    case (mem_mem_addr[1:0])
      2'd0:    ld_b = rdata_q[7:0];
      2'd1:    ld_b = rdata_q[15:8];
      2'd2:    ld_b = rdata_q[23:16];
      default: ld_b = rdata_q[31:24];
    endcase
    ld_h = mem_mem_addr[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (size)
      2'd0:    ld_data = {{24{sgn & ld_b[7]}}, ld_b};
      2'd1:    ld_data = {{16{sgn & ld_h[15]}}, ld_h};
      default: ld_data = rdata_q;
    endcase
  end

  always_comb begin
    wd_o       = '0;
    wreg_o     = 1'b0;
    wdata_o    = '0;
    stallreq_o = 1'b0;
    adel_o     = 1'b0;
    ades_o     = 1'b0;
    badvaddr_o = '0;
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_size  = 2'd0;
    data_addr  = '0;
    data_wdata = '0;
    if (!rst) begin
      wd_o       = mem_wd;
      wreg_o     = mem_wreg & ~misalign & ~flush;
      wdata_o    = (state_q == S_DONE && is_load) ? ld_data : mem_wdata;
      stallreq_o = issue | (state_q == S_REQ) | (state_q == S_WAIT)
                 | (state_q == S_DRAIN);
      adel_o     = is_load & misalign;
      ades_o     = is_store & misalign;
      badvaddr_o = mem_mem_addr;
      data_req   = issue | (state_q == S_REQ);
      data_wr    = is_store;
      data_size  = size;
      data_addr  = mem_mem_addr;
      case (size)
        2'd0:    data_wdata = {4{mem_reg2[7:0]}};
        2'd1:    data_wdata = {2{mem_reg2[15:0]}};
        default: data_wdata = mem_reg2;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: random and directed bench for the MEM-stage load/store unit.
// Expectations come from a cycle-timeline model of the access protocol.
module tb_mem_access;

  localparam logic [7:0] LB  = 8'b1110_0000;
  localparam logic [7:0] LBU = 8'b1110_0100;
  localparam logic [7:0] LH  = 8'b1110_0001;
  localparam logic [7:0] LHU = 8'b1110_0101;
  localparam logic [7:0] LW  = 8'b1110_0011;
  localparam logic [7:0] SB  = 8'b1110_1000;
  localparam logic [7:0] SH  = 8'b1110_1001;
  localparam logic [7:0] SW  = 8'b1110_1011;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_mem_addr, mem_reg2, mem_wdata;
  logic [4:0]  mem_wd;
  logic        mem_wreg, flush;
  logic [4:0]  wd_o;
  logic        wreg_o, stallreq_o, adel_o, ades_o;
  logic [31:0] wdata_o, badvaddr_o;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .rst(rst),
    .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr),
    .mem_reg2(mem_reg2), .mem_wd(mem_wd),
    .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .flush(flush),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .stallreq_o(stallreq_o), .adel_o(adel_o), .ades_o(ades_o),
    .badvaddr_o(badvaddr_o),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_rdata(data_rdata),
    .data_data_ok(data_data_ok)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int op_bytes(input logic [7:0] op);
    case (op)
      LB, LBU, SB: return 1;
      LH, LHU, SH: return 2;
      LW, SW:      return 4;
      default:     return 0;
    endcase
  endfunction

  function automatic bit op_load(input logic [7:0] op);
    return op == LB || op == LBU || op == LH || op == LHU || op == LW;
  endfunction

  function automatic bit op_store(input logic [7:0] op);
    return op == SB || op == SH || op == SW;
  endfunction

  function automatic logic [31:0] ref_load(input logic [7:0] op,
      input logic [31:0] addr, input logic [31:0] w);
    logic [31:0] v;
    case (op)
      LB, LBU: begin
        v = (w >> (8 * (addr % 4))) & 32'hFF;
        if (op == LB && v >= 32'd128) v = v - 32'd256;
      end
      LH, LHU: begin
        v = (w >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
        if (op == LH && v >= 32'd32768) v = v - 32'd65536;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [7:0] op,
      input logic [31:0] r);
    case (op_bytes(op))
      1:       return (r & 32'hFF) * 32'h0101_0101;
      2:       return (r & 32'hFFFF) * 32'h0001_0001;
      default: return r;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inst(input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] r2);
    mem_aluop    = op;
    mem_mem_addr = addr;
    mem_reg2     = r2;
    mem_wd       = 5'($urandom);
    mem_wreg     = 1'($urandom);
    mem_wdata    = $urandom;
  endtask

  // Aligned access: addr_ok in cycle da, data_ok dd cycles later, DONE after.
  task automatic run_mem(input logic [7:0] op, input logic [31:0] addr,
      input logic [31:0] r2, input logic [31:0] rd, input int da,
      input int dd);
    int last;
    last = da + dd + 1;
    set_inst(op, addr, r2);
    for (int c = 0; c <= last; c++) begin
      data_addr_ok = (c == da);
      data_data_ok = (c == da + dd);
      data_rdata   = (c == da + dd) ? rd : $urandom;
      @(negedge clk);
      chk("stall", 32'(stallreq_o), 32'(c < last));
      chk("req", 32'(data_req), 32'(c <= da));
      if (c <= da) begin
        chk("addr", data_addr, addr);
        chk("wr", 32'(data_wr), 32'(op_store(op)));
        chk("size", 32'(data_size), 32'(op_bytes(op) / 2));
        if (op_store(op)) chk("wdata_bus", data_wdata, ref_store(op, r2));
      end
      chk("wreg", 32'(wreg_o), 32'(mem_wreg));
      chk("wd", 32'(wd_o), 32'(mem_wd));
      if (c == last && op_load(op))
        chk("ld_data", wdata_o, ref_load(op, addr, rd));
      else
        chk("wdata", wdata_o, mem_wdata);
      tick();
    end
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
  endtask

  // Non-memory or misaligned op: one pass-through cycle, no bus activity.
  task automatic run_single(input logic [7:0] op, input logic [31:0] addr);
    int  b;
    bit  mis;
    set_inst(op, addr, $urandom);
    @(negedge clk);
    b   = op_bytes(op);
    mis = (b > 0) && (addr % b != 0);
    chk("s_stall", 32'(stallreq_o), 32'(0));
    chk("s_req", 32'(data_req), 32'(0));
    chk("adel", 32'(adel_o), 32'(mis && op_load(op)));
    chk("ades", 32'(ades_o), 32'(mis && op_store(op)));
    chk("badv", badvaddr_o, addr);
    chk("s_wreg", 32'(wreg_o), 32'(mem_wreg && !mis));
    chk("s_wdata", wdata_o, mem_wdata);
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, 32'(data_req), 32'(0));
    chk({tag, "_wr"}, 32'(data_wr), 32'(0));
    chk({tag, "_size"}, 32'(data_size), 32'(0));
    chk({tag, "_addr"}, data_addr, 32'(0));
    chk({tag, "_bwdata"}, data_wdata, 32'(0));
    chk({tag, "_stall"}, 32'(stallreq_o), 32'(0));
    chk({tag, "_wd"}, 32'(wd_o), 32'(0));
    chk({tag, "_wreg"}, 32'(wreg_o), 32'(0));
    chk({tag, "_wdata"}, wdata_o, 32'(0));
    chk({tag, "_adel"}, 32'(adel_o), 32'(0));
    chk({tag, "_ades"}, 32'(ades_o), 32'(0));
    chk({tag, "_badv"}, badvaddr_o, 32'(0));
  endtask

  logic [7:0] ops [10];

  initial begin
    ops = '{LB, LBU, LH, LHU, LW, SB, SH, SW, 8'h21, 8'h00};
    rst = 1'b1;
    flush = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata = 32'hDEAD_BEEF;
    set_inst(SW, 32'h0000_1234, 32'hCAFE_F00D);
    mem_wreg = 1'b1;
    @(negedge clk);
    chk_all_zero("rst");
    tick();
    rst = 1'b0;

    run_mem(LW, 32'h1000, 32'h0, 32'h89AB_CDEF, 0, 1);
    run_mem(LB, 32'h1003, 32'h0, 32'h80FF_FFFF, 0, 1);
    run_mem(LBU, 32'h1003, 32'h0, 32'h80FF_FFFF, 0, 1);
    run_mem(LHU, 32'h1002, 32'h0, 32'h80FF_FFFF, 0, 1);
    run_mem(SH, 32'h2002, 32'h1234_ABCD, 32'h0, 3, 1);
    run_single(LW, 32'h1001);
    run_single(SW, 32'h1002);

    // flush during WAIT: drain, no new request while the LW is still present
    set_inst(LW, 32'h3000, 32'h0);
    data_addr_ok = 1'b1;
    @(negedge clk);
    chk("fw_req0", 32'(data_req), 32'(1));
    tick();
    data_addr_ok = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    chk("fw_stall1", 32'(stallreq_o), 32'(1));
    chk("fw_wreg1", 32'(wreg_o), 32'(0));
    tick();
    flush = 1'b0;
    for (int c = 2; c <= 3; c++) begin
      data_data_ok = (c == 3);
      data_rdata = $urandom;
      @(negedge clk);
      chk("fw_stall", 32'(stallreq_o), 32'(1));
      chk("fw_req", 32'(data_req), 32'(0));
      tick();
    end
    data_data_ok = 1'b0;
    run_mem(LW, 32'h3004, 32'h0, 32'h1357_9BDF, 1, 2);

    // flush during REQ: request withdrawn next cycle
    set_inst(LW, 32'h4000, 32'h0);
    @(negedge clk);
    chk("fr_req0", 32'(data_req), 32'(1));
    tick();
    flush = 1'b1;
    @(negedge clk);
    chk("fr_req1", 32'(data_req), 32'(1));
    chk("fr_wreg1", 32'(wreg_o), 32'(0));
    tick();
    flush = 1'b0;
    run_single(8'h00, 32'h4000);
    run_mem(LH, 32'h4002, 32'h0, 32'h8001_7FFF, 0, 1);

    // data_ok together with flush in WAIT still completes via DONE
    set_inst(LHU, 32'h5002, 32'h0);
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    data_rdata = 32'hA5A5_0000;
    flush = 1'b1;
    @(negedge clk);
    chk("df_stall", 32'(stallreq_o), 32'(1));
    chk("df_wreg", 32'(wreg_o), 32'(0));
    tick();
    data_data_ok = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("df_done_stall", 32'(stallreq_o), 32'(0));
    chk("df_done_data", wdata_o, 32'h0000_A5A5);
    tick();

    // asynchronous reset in the middle of WAIT
    set_inst(LW, 32'h6000, 32'h0);
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    #2 rst = 1'b1;
    #1 chk_all_zero("arst");
    tick();
    rst = 1'b0;
    run_mem(LW, 32'h6004, 32'h0, 32'h2468_ACE0, 0, 1);

    for (int i = 0; i < 200; i++) begin
      logic [7:0]  op;
      logic [31:0] a;
      int          b;
      op = ops[$urandom_range(0, 9)];
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & 32'hFFFF_FFFC | 32'($urandom_range(0, 3) & (op_bytes(op) == 1 ? 3 : op_bytes(op) == 2 ? 2 : 0));
      b = op_bytes(op);
      if (b > 0 && a % b == 0)
        run_mem(op, a, $urandom, $urandom, $urandom_range(0, 3),
                $urandom_range(1, 3));
      else
        run_single(op, a);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
